mem_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port synchronous `memory` block. Accepts one read or write command at a time from either requester, drives the memory's `addr`/`wr_en`/`rd_en`/`wdata` strobes for exactly one cycle, and routes the read data back to the requester that issued the read. It sits between the two bus masters and the memory, and is the only block that drives the memory's command pins.

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-port memory; round-robin by default,
// fixed priority (requester 0 wins ties) when MEM_ARB_FIXED_PRIO_EN is defined.
//
// state  | meaning
// IDLE   | sample requests, latch winner's command, pulse gnt
// ISSUE  | memory strobe high for one cycle
// RDWAIT | capture mem_rdata, pulse owner's rvalid
module mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t                state, state_nxt;
  logic                  lat_we, lat_we_nxt;
  logic                  owner, owner_nxt;
  logic                  pick1;
  logic                  gnt0_nxt, gnt1_nxt, rvalid0_nxt, rvalid1_nxt;
  logic                  busy_nxt, wr_en_nxt, rd_en_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt, rdata_nxt;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  // last = 1 means requester 1 won the previous grant, so a tie goes to 0
  logic last, last_nxt;

  assign pick1    = req1 & (~req0 | ~last);
  assign last_nxt = (state == IDLE && (req0 || req1)) ? pick1 : last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last <= 1'b1;
    else        last <= last_nxt;
  end
`endif

  always_comb begin
    state_nxt   = state;
    lat_we_nxt  = lat_we;
    owner_nxt   = owner;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    rdata_nxt   = rdata;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    rvalid0_nxt = 1'b0;
    rvalid1_nxt = 1'b0;
    busy_nxt    = 1'b0;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_nxt  = pick1;
          lat_we_nxt = pick1 ? we1 : we0;
          addr_nxt   = pick1 ? addr1 : addr0;
          wdata_nxt  = pick1 ? wdata1 : wdata0;
          gnt0_nxt   = ~pick1;
          gnt1_nxt   = pick1;
          wr_en_nxt  = lat_we_nxt;
          rd_en_nxt  = ~lat_we_nxt;
          busy_nxt   = 1'b1;
          state_nxt  = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_we) begin
          state_nxt = IDLE;
        end else begin
          busy_nxt  = 1'b1;
          state_nxt = RDWAIT;
        end
      end
      RDWAIT: begin
        rdata_nxt   = mem_rdata;
        rvalid0_nxt = ~owner;
        rvalid1_nxt = owner;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      owner     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      busy      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_we    <= lat_we_nxt;
      owner     <= owner_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      rdata     <= rdata_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      rvalid0   <= rvalid0_nxt;
      rvalid1   <= rvalid1_nxt;
      busy      <= busy_nxt;
      mem_wr_en <= wr_en_nxt;
      mem_rd_en <= rd_en_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-timeline reference model with per-requester command
// queues, directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

  localparam int NC = 4096;

  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [3:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;
  logic       gnt0, gnt1, rvalid0, rvalid1, busy, mem_wr_en, mem_rd_en;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_addr;

  mem_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory block stand-in: data valid the cycle after rd_en is sampled
  logic [7:0] tb_mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_wr_en) tb_mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= tb_mem[mem_addr];
  end

  // reference model state
  logic [7:0] ref_mem [16] = '{default: 8'h00};
  bit         e_g0 [NC], e_g1 [NC], e_wr [NC], e_rd [NC], e_busy [NC], e_rv0 [NC], e_rv1 [NC];
  bit         u_a [NC], u_r [NC];
  logic [3:0] u_a_v [NC];
  logic [7:0] u_w_v [NC], u_r_v [NC];
  logic [3:0] m_addr = '0;
  logic [7:0] m_wdata = '0, m_rdata = '0;
  bit         last = 1'b1;
  int         cyc = 0, free_at = 0, rdwait_cyc = -1, pop0_at = -1, pop1_at = -1;
  int         tests = 0, fails = 0;
  cmd_t       q0 [$], q1 [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_now();
    chk("gnt0", {7'd0, gnt0}, {7'd0, e_g0[cyc]});
    chk("gnt1", {7'd0, gnt1}, {7'd0, e_g1[cyc]});
    chk("mem_wr_en", {7'd0, mem_wr_en}, {7'd0, e_wr[cyc]});
    chk("mem_rd_en", {7'd0, mem_rd_en}, {7'd0, e_rd[cyc]});
    chk("busy", {7'd0, busy}, {7'd0, e_busy[cyc]});
    chk("rvalid0", {7'd0, rvalid0}, {7'd0, e_rv0[cyc]});
    chk("rvalid1", {7'd0, rvalid1}, {7'd0, e_rv1[cyc]});
    chk("mem_addr", {4'd0, mem_addr}, {4'd0, m_addr});
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("rdata", rdata, m_rdata);
  endtask

  task automatic model_reset();
    for (int i = cyc; i < NC; i++) begin
      e_g0[i] = 0; e_g1[i] = 0; e_wr[i] = 0; e_rd[i] = 0; e_busy[i] = 0;
      e_rv0[i] = 0; e_rv1[i] = 0; u_a[i] = 0; u_r[i] = 0;
    end
    m_addr = '0; m_wdata = '0; m_rdata = '0;
    last = 1'b1; free_at = 0; rdwait_cyc = -1;
  endtask

  task automatic drive();
    if (q0.size() > 0) begin
      req0 = 1'b1; we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].wdata;
    end else begin
      req0 = 1'b0; we0 = 1'($urandom); addr0 = 4'($urandom); wdata0 = 8'($urandom);
    end
    if (q1.size() > 0) begin
      req1 = 1'b1; we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].wdata;
    end else begin
      req1 = 1'b0; we1 = 1'($urandom); addr1 = 4'($urandom); wdata1 = 8'($urandom);
    end
  endtask

  // An IDLE sample at cycle t: gnt/strobe at t+1, write done by t+2, read data at t+3.
  task automatic sample();
    bit   v0, v1, w;
    cmd_t c;
    int   g;
    v0 = q0.size() > 0;
    v1 = q1.size() > 0;
    if (!v0 && !v1) return;
`ifdef MEM_ARB_FIXED_PRIO_EN
    w = !v0;
`else
    w = (v0 && v1) ? !last : !v0;
`endif
    last = w;
    c = w ? q1[0] : q0[0];
    g = cyc + 1;
    if (w) begin e_g1[g] = 1; pop1_at = cyc + 2; end
    else   begin e_g0[g] = 1; pop0_at = cyc + 2; end
    e_busy[g] = 1;
    u_a[g] = 1; u_a_v[g] = c.addr; u_w_v[g] = c.wdata;
    if (c.we) begin
      e_wr[g] = 1;
      ref_mem[c.addr] = c.wdata;
      free_at = cyc + 2;
    end else begin
      e_rd[g] = 1;
      e_busy[cyc+2] = 1;
      rdwait_cyc = cyc + 2;
      if (w) e_rv1[cyc+3] = 1; else e_rv0[cyc+3] = 1;
      u_r[cyc+3] = 1; u_r_v[cyc+3] = ref_mem[c.addr];
      free_at = cyc + 3;
    end
  endtask

  task automatic step(input bit rel);
    @(posedge clk);
    #1;
    cyc++;
    if (u_a[cyc]) begin m_addr = u_a_v[cyc]; m_wdata = u_w_v[cyc]; end
    if (u_r[cyc]) m_rdata = u_r_v[cyc];
    check_now();
    if (rel) reset = 1'b1;
    if (pop0_at == cyc) begin void'(q0.pop_front()); pop0_at = -1; end
    if (pop1_at == cyc) begin void'(q1.pop_front()); pop1_at = -1; end
    drive();
    if (reset && cyc >= free_at && cyc + 3 < NC) sample();
  endtask

  task automatic run_until_idle();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || cyc < free_at) && n < 300) begin
      step(1'b0);
      n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $error("FAIL drain_timeout cyc=%0d observed=busy expected=idle", cyc);
    end
  endtask

  function automatic cmd_t mk(input bit we, input logic [3:0] a, input logic [7:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d;
    return c;
  endfunction

  initial begin
    #2 reset = 1'b0;
    // reset held for two cycles with a pending request: nothing granted
    q0.push_back(mk(1'b1, 4'h3, 8'hA5));
    drive();
    step(1'b0);
    step(1'b0);
    step(1'b1);
    q0.push_back(mk(1'b0, 4'h3, 8'($urandom)));
    run_until_idle();

    // tie: both requesters stream reads
    q0.push_back(mk(1'b1, 4'h1, 8'($urandom)));
    q1.push_back(mk(1'b1, 4'h2, 8'($urandom)));
    run_until_idle();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 4'h1, 8'($urandom)));
      q1.push_back(mk(1'b0, 4'h2, 8'($urandom)));
    end
    run_until_idle();

    // back-to-back writes from requester 1, then read-back
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b1, 4'(i), 8'($urandom)));
    run_until_idle();
    for (int i = 0; i < 4; i++) q1.push_back(mk(1'b0, 4'(i), 8'($urandom)));
    run_until_idle();

    // reset while a read is in RDWAIT; requester 1 pending across reset
    q0.push_back(mk(1'b1, 4'h5, 8'h3C));
    run_until_idle();
    q0.push_back(mk(1'b0, 4'h5, 8'($urandom)));
    begin
      int n = 0;
      while (cyc != rdwait_cyc && n < 20) begin step(1'b0); n++; end
      if (n >= 20) begin
        tests++; fails++;
        $error("FAIL rdwait_timeout cyc=%0d observed=none expected=rdwait", cyc);
      end
    end
    reset = 1'b0;
    model_reset();
    q1.push_back(mk(1'b1, 4'h7, 8'($urandom)));
    drive();
    #1;
    check_now();
    step(1'b0);
    step(1'b1);
    q1.push_back(mk(1'b0, 4'h7, 8'($urandom)));
    run_until_idle();

    // randomized traffic
    for (int i = 0; i < 1200; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) == 0)
        q0.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom)));
      if (q1.size() == 0 && $urandom_range(0, 2) == 0)
        q1.push_back(mk(1'($urandom), 4'($urandom), 8'($urandom)));
      step(1'b0);
    end
    run_until_idle();
    step(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
